alu_op_sequencer: RTL and testbench

//  Synthesizable driver and capture engine for the 8-bit ALU (a, b, operation[3:0] -> z[8:0]).
//  On start, it latches one operand pair and sweeps operation codes OP_FIRST..OP_LAST.
//  It holds each code for HOLD_CYCLES, samples z, and queues {op, z} in a result FIFO.
//  A host drains the FIFO over a valid/ready port. Sits between the host/control logic and the ALU.

---
 rtl/alu_op_sequencer_if.sv | 37 +++
 rtl/alu_op_sequencer.sv | 135 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_sequencer_if
//  Brief    : Host-side and ALU-side signal bundle for alu_op_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_op_sequencer_if #(
    parameter int DEPTH = 16
) ();
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic               start;
    logic [7:0]         a_in;
    logic [7:0]         b_in;
    logic               busy;
    logic               done;
    logic [7:0]         alu_a;
    logic [7:0]         alu_b;
    logic [3:0]         alu_op;
    logic [8:0]         alu_z;
    logic               res_valid;
    logic               res_ready;
    logic [3:0]         res_op;
    logic [8:0]         res_z;
    logic [c_CNT_W-1:0] fifo_count;

    modport master (
        input  start, a_in, b_in, alu_z, res_ready,
        output busy, done, alu_a, alu_b, alu_op, res_valid, res_op, res_z, fifo_count
    );

    modport slave (
        output start, a_in, b_in, alu_z, res_ready,
        input  busy, done, alu_a, alu_b, alu_op, res_valid, res_op, res_z, fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_sequencer
//  Brief    : Sweeps ALU op codes on a latched operand pair, queues {op, z}.
//  Revision : 1.0  initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int OP_FIRST    = 0,
    parameter int OP_LAST     = 9,
    parameter int HOLD_CYCLES = 5,
    parameter int DEPTH       = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    alu_op_sequencer_if.master    bus
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [3:0]      c_OP_FIRST  = 4'(OP_FIRST);
    localparam logic [3:0]      c_OP_LAST   = 4'(OP_LAST);
    localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(HOLD_CYCLES - 1);
    localparam logic [c_AW:0]   c_DEPTH     = (c_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_HW-1:0]   r_hold_cnt;
    logic              r_busy;
    logic              r_done;
    logic [7:0]        r_alu_a;
    logic [7:0]        r_alu_b;
    logic [3:0]        r_alu_op;

    logic [3:0]        r_mem_op [DEPTH];
    logic [8:0]        r_mem_z  [DEPTH];
    logic [c_AW-1:0]   r_wptr;
    logic [c_AW-1:0]   r_rptr;
    logic [c_AW:0]     r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_sample;
    logic w_push;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_DEPTH);
    assign w_pop    = !w_empty && bus.res_ready;
    assign w_sample = (r_state == S_DRIVE) && (r_hold_cnt == c_HOLD_LAST);
    // A full FIFO still accepts the push when the host frees a slot this cycle.
    assign w_push   = w_sample && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= c_OP_FIRST;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_alu_a    <= bus.a_in;
                        r_alu_b    <= bus.b_in;
                        r_alu_op   <= c_OP_FIRST;
                        r_hold_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    // Without w_push at the sample point everything stays frozen (stall).
                    if (!w_sample) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end else if (w_push) begin
                        if (r_alu_op == c_OP_LAST) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_alu_op   <= r_alu_op + 4'd1;
                            r_hold_cnt <= '0;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wptr] <= r_alu_op;
            r_mem_z[r_wptr]  <= bus.alu_z;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_op     = r_alu_op;
    assign bus.res_valid  = !w_empty;
    // Head is masked while empty so the outputs read zero after reset.
    assign bus.res_op     = w_empty ? 4'd0 : r_mem_op[r_rptr];
    assign bus.res_z      = w_empty ? 9'd0 : r_mem_z[r_rptr];
    assign bus.fifo_count = r_count;
endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_op_sequencer
//  Brief    : Randomised self-checking bench with an ALU model and result queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_op_sequencer;
    localparam int OP_FIRST = 0;
    localparam int OP_LAST  = 9;
    localparam int HOLD     = 5;
    localparam int DEPTH    = 4;
    localparam int N_OPS    = OP_LAST - OP_FIRST + 1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    logic [12:0] got[$];
    logic [12:0] exp[$];

    alu_op_sequencer_if #(.DEPTH(DEPTH)) bus ();

    alu_op_sequencer #(
        .OP_FIRST(OP_FIRST), .OP_LAST(OP_LAST), .HOLD_CYCLES(HOLD), .DEPTH(DEPTH)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op);
        case (op)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {1'b0, a} - {1'b0, b};
            4'd2:    return {1'b0, a & b};
            4'd3:    return {1'b0, a | b};
            4'd4:    return {1'b0, a ^ b};
            4'd5:    return {1'b0, ~a};
            4'd6:    return {a, 1'b0};
            4'd7:    return {2'b0, a[7:1]};
            4'd8:    return {1'b0, a} + 9'd1;
            4'd9:    return {1'b0, a} - 9'd1;
            default: return {1'b0, a};
        endcase
    endfunction

    assign bus.alu_z = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst === 1'b0 && bus.res_valid === 1'b1 && bus.res_ready === 1'b1)
            got.push_back({bus.res_op, bus.res_z});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_expected(input logic [7:0] a, input logic [7:0] b);
        for (int op = OP_FIRST; op <= OP_LAST; op++)
            exp.push_back({4'(op), alu_ref(a, b, 4'(op))});
    endtask

    // Pulses start and waits for done, optionally toggling res_ready randomly.
    task automatic run_sweep(input logic [7:0] a, input logic [7:0] b, input bit rnd,
                             output bit ok);
        ok = 1'b0;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (rnd) bus.res_ready = 1'($urandom_range(0, 1));
            step();
        end
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (bus.fifo_count === '0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.a_in = 8'hA5;
        bus.b_in = 8'h5A;
        bus.res_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        bus.start = 1'b0;
        n_checks++;
        if ({bus.busy, bus.done, bus.res_valid} !== 3'b000)
            $display("FAIL reset_flags: busy/done/valid=%b expected 000",
                     {bus.busy, bus.done, bus.res_valid});
        else n_pass++;
        n_checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op} !== {8'd0, 8'd0, 4'(OP_FIRST)})
            $display("FAIL reset_alu: a=%0d b=%0d op=%0d expected 0 0 %0d",
                     bus.alu_a, bus.alu_b, bus.alu_op, OP_FIRST);
        else n_pass++;
        n_checks++;
        if ({bus.fifo_count, bus.res_op, bus.res_z} !== '0)
            $display("FAIL reset_fifo: count=%0d op=%0d z=%0d expected 0",
                     bus.fifo_count, bus.res_op, bus.res_z);
        else n_pass++;
        step();
        n_checks++;
        if (bus.busy !== 1'b0)
            $display("FAIL reset_start_ignored: busy=%b expected 0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_latency();
        logic [3:0] e_op;
        got.delete();
        exp.delete();
        add_expected(8'd12, 8'd4);
        bus.a_in = 8'd12;
        bus.b_in = 8'd4;
        bus.res_ready = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int t = 1; t <= N_OPS * HOLD + 1; t++) begin
            e_op = 4'(OP_FIRST + ((t <= N_OPS * HOLD) ? (t - 1) / HOLD : N_OPS - 1));
            n_checks++;
            if (bus.alu_op !== e_op)
                $display("FAIL lat_op c%0d: op=%0d expected %0d", t, bus.alu_op, e_op);
            else n_pass++;
            n_checks++;
            if (bus.busy !== 1'(t <= N_OPS * HOLD))
                $display("FAIL lat_busy c%0d: busy=%b", t, bus.busy);
            else n_pass++;
            n_checks++;
            if (bus.done !== 1'(t == N_OPS * HOLD + 1))
                $display("FAIL lat_done c%0d: done=%b", t, bus.done);
            else n_pass++;
            n_checks++;
            if (bus.res_valid !== 1'(t > 1 && (t - 1) % HOLD == 0))
                $display("FAIL lat_valid c%0d: valid=%b", t, bus.res_valid);
            else n_pass++;
            if (t <= N_OPS * HOLD) step();
        end
        n_checks++;
        if ({bus.alu_a, bus.alu_b} !== {8'd12, 8'd4})
            $display("FAIL lat_operands: a=%0d b=%0d expected 12 4", bus.alu_a, bus.alu_b);
        else n_pass++;
        repeat (3) step();
        n_checks++;
        if (got.size() !== exp.size())
            $display("FAIL lat_entries: got %0d expected %0d", got.size(), exp.size());
        else n_pass++;
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp[i]) $display("FAIL lat_entry%0d: got %h expected %h", i, got[i], exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        logic [7:0] a;
        logic [7:0] b;
        bit ok;
        a = 8'($urandom);
        b = 8'($urandom);
        got.delete();
        exp.delete();
        add_expected(a, b);
        bus.res_ready = 1'b0;
        bus.a_in = a;
        bus.b_in = b;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (40) step();
        n_checks++;
        if ({bus.fifo_count, bus.alu_op, bus.busy} !== {3'(DEPTH), 4'(OP_FIRST + DEPTH), 1'b1})
            $display("FAIL stall_state: count=%0d op=%0d busy=%b expected %0d %0d 1",
                     bus.fifo_count, bus.alu_op, bus.busy, DEPTH, OP_FIRST + DEPTH);
        else n_pass++;
        n_checks++;
        if ({bus.res_valid, bus.res_op} !== {1'b1, 4'(OP_FIRST)})
            $display("FAIL stall_head: valid=%b op=%0d expected 1 %0d",
                     bus.res_valid, bus.res_op, OP_FIRST);
        else n_pass++;
        repeat (20) step();
        n_checks++;
        if ({bus.fifo_count, bus.alu_op} !== {3'(DEPTH), 4'(OP_FIRST + DEPTH)})
            $display("FAIL stall_frozen: count=%0d op=%0d", bus.fifo_count, bus.alu_op);
        else n_pass++;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            bus.res_ready = 1'($urandom_range(0, 1));
            step();
            n_checks++;
            if (bus.fifo_count > 3'(DEPTH))
                $display("FAIL stall_overflow: count=%0d", bus.fifo_count);
            else n_pass++;
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) $display("FAIL stall_resume: done=0 expected a done pulse within 1000 cycles");
        else n_pass++;
        drain(ok);
        n_checks++;
        if (got.size() !== exp.size() || !ok)
            $display("FAIL stall_entries: got %0d expected %0d", got.size(), exp.size());
        else n_pass++;
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp[i]) $display("FAIL stall_entry%0d: got %h expected %h", i, got[i], exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_restart_ignored();
        int pulses;
        bit ok;
        got.delete();
        exp.delete();
        add_expected(8'd12, 8'd4);
        pulses = 0;
        bus.res_ready = 1'b1;
        bus.a_in = 8'd12;
        bus.b_in = 8'd4;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int t = 1; t < 200; t++) begin
            if (t == 10) begin
                bus.start = 1'b1;
                bus.a_in = 8'd99;
            end else if (t == 11) begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) break;
            n_checks++;
            if (bus.alu_a !== 8'd12) $display("FAIL restart_alu_a c%0d: a=%0d expected 12", t, bus.alu_a);
            else n_pass++;
            step();
        end
        bus.start = 1'b1;
        bus.a_in = 8'd77;
        for (int t = 0; t < 12; t++) begin
            if (bus.done === 1'b1) pulses++;
            step();
            bus.start = 1'b0;
            n_checks++;
            if (bus.busy !== 1'b0) $display("FAIL restart_in_done: busy=%b expected 0", bus.busy);
            else n_pass++;
        end
        n_checks++;
        if (pulses !== 1) $display("FAIL restart_done_pulses: got %0d expected 1", pulses);
        else n_pass++;
        drain(ok);
        n_checks++;
        if (got.size() !== exp.size() || !ok)
            $display("FAIL restart_entries: got %0d expected %0d", got.size(), exp.size());
        else n_pass++;
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp[i]) $display("FAIL restart_entry%0d: got %h expected %h", i, got[i], exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] a;
        logic [7:0] b;
        bit ok;
        bit ok2;
        bus.res_ready = 1'b0;
        bus.a_in = 8'd12;
        bus.b_in = 8'd4;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (19) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({bus.busy, bus.res_valid, bus.fifo_count, bus.alu_op, bus.done} !==
            {1'b0, 1'b0, 3'd0, 4'(OP_FIRST), 1'b0})
            $display("FAIL midreset_state: busy=%b valid=%b count=%0d op=%0d done=%b",
                     bus.busy, bus.res_valid, bus.fifo_count, bus.alu_op, bus.done);
        else n_pass++;
        got.delete();
        exp.delete();
        a = 8'($urandom);
        b = 8'($urandom);
        add_expected(a, b);
        bus.res_ready = 1'b1;
        run_sweep(a, b, 1'b0, ok);
        drain(ok2);
        n_checks++;
        if (got.size() !== exp.size() || !ok || !ok2)
            $display("FAIL midreset_entries: got %0d expected %0d done_seen=%b", got.size(), exp.size(), ok);
        else n_pass++;
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp[i]) $display("FAIL midreset_entry%0d: got %h expected %h", i, got[i], exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_carry();
        bit ok;
        bit ok2;
        got.delete();
        exp.delete();
        add_expected(8'd255, 8'd255);
        bus.res_ready = 1'b1;
        run_sweep(8'd255, 8'd255, 1'b0, ok);
        drain(ok2);
        n_checks++;
        if (got.size() !== exp.size() || !ok || !ok2)
            $display("FAIL carry_entries: got %0d expected %0d", got.size(), exp.size());
        else n_pass++;
        n_checks++;
        if (got.size() == 0 || got[0] !== {4'd0, 9'h1FE})
            $display("FAIL carry_add: got %h expected %h", (got.size() > 0) ? got[0] : 13'h0, {4'd0, 9'h1FE});
        else n_pass++;
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp[i]) $display("FAIL carry_entry%0d: got %h expected %h", i, got[i], exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a1;
        logic [7:0] b1;
        logic [7:0] a2;
        logic [7:0] b2;
        bit ok1;
        bit ok2;
        bit ok3;
        a1 = 8'($urandom);
        b1 = 8'($urandom);
        a2 = 8'($urandom);
        b2 = 8'($urandom);
        got.delete();
        exp.delete();
        add_expected(a1, b1);
        add_expected(a2, b2);
        bus.res_ready = 1'b0;
        run_sweep(a1, b1, 1'b1, ok1);
        step();
        run_sweep(a2, b2, 1'b1, ok2);
        drain(ok3);
        n_checks++;
        if (!ok1 || !ok2 || !ok3)
            $display("FAIL b2b_done: done seen=%b%b drained=%b expected 111", ok1, ok2, ok3);
        else n_pass++;
        n_checks++;
        if (got.size() !== exp.size())
            $display("FAIL b2b_entries: got %0d expected %0d", got.size(), exp.size());
        else n_pass++;
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp[i]) $display("FAIL b2b_entry%0d: got %h expected %h", i, got[i], exp[i]);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_latency();
        test_stall();
        test_restart_ignored();
        test_reset_mid();
        test_carry();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule
`default_nettype wire
